branch_unit: RTL and testbench



---
 rtl/branch_pkg.sv | 36 +++
 rtl/branch_cond.sv | 50 +++++
 rtl/branch_unit.sv | 215 +++++++++++++++++++++
 tb/tb_branch_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// ----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the EX-stage branch unit:
//   - RISC-V branch funct3 encodings (F3_BEQ .. F3_BGEU)
//   - br_state_t : IDLE / SHADOW redirect-shadow FSM encoding
//   - SHADOW_CNT_W : width of the shadow-window down-counter
//   - sat_inc32() : saturating increment for the optional statistics counters
// ----------------------------------------------------------------------------
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SHADOW = 1'b1
    } br_state_t;

    localparam int SHADOW_CNT_W = 4;

    // Counter increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// ----------------------------------------------------------------------------
// branch_cond
// Purely combinational RISC-V branch condition evaluator.
// Ports:
//   funct3  in  3           branch funct3
//   a, b    in  DATA_WIDTH  operands (rs1, rs2)
//   taken   out 1           condition true (always 0 for illegal funct3)
//   illegal out 1           funct3 is 010 or 011 (no branch defined)
// Equality, signed less-than and unsigned less-than are each computed once
// and the result is selected by funct3.
// ----------------------------------------------------------------------------
module branch_cond
    import branch_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  taken,
    output logic                  illegal
);

    logic eq_s;
    logic lt_signed_s;
    logic lt_unsigned_s;

    assign eq_s          = (a == b);
    assign lt_signed_s   = ($signed(a) < $signed(b));
    assign lt_unsigned_s = (a < b);

    // Select the condition for this funct3; unknown encodings flag illegal.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = eq_s;
            F3_BNE:  taken = ~eq_s;
            F3_BLT:  taken = lt_signed_s;
            F3_BGE:  taken = ~lt_signed_s;
            F3_BLTU: taken = lt_unsigned_s;
            F3_BGEU: taken = ~lt_unsigned_s;
            default: begin
                taken   = 1'b0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// ----------------------------------------------------------------------------
// branch_unit
// EX-stage branch resolver. Accepts a branch when br_valid & ~stall &
// ~flush_in in IDLE, registers taken/target one cycle later, and pulses
// redirect for an aligned taken branch. After a redirect, br_valid is
// squashed for SHADOW_CYCLES non-stalled cycles (wrong-path instructions).
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   br_valid, br_funct3  branch request and its funct3
//   rs1_data, rs2_data   operands
//   pc, imm              branch PC and sign-extended offset
//   stall                blocks acceptance, freezes the shadow counter
//   flush_in             external flush, highest priority
//   res_valid            pulse: taken/target valid
//   taken, target        resolved condition and pc+imm (held between results)
//   redirect             pulse: fetch loads target
//   illegal              pulse: unsupported funct3
//   misalign             pulse: taken branch to non word-aligned target
// Optional: define BRANCH_STATS_EN to add saturating 32-bit counters
//   taken_cnt, not_taken_cnt, squash_cnt.
// ----------------------------------------------------------------------------
module branch_unit
    import branch_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int SHADOW_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  br_valid,
    input  logic [2:0]            br_funct3,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [ADDR_WIDTH-1:0] imm,
    input  logic                  stall,
    input  logic                  flush_in,
    output logic                  res_valid,
    output logic                  taken,
    output logic [ADDR_WIDTH-1:0] target,
    output logic                  redirect,
    output logic                  illegal,
`ifdef BRANCH_STATS_EN
    output logic [31:0]           taken_cnt,
    output logic [31:0]           not_taken_cnt,
    output logic [31:0]           squash_cnt,
`endif
    output logic                  misalign
);

    localparam logic [SHADOW_CNT_W-1:0] SHADOW_INIT = SHADOW_CNT_W'(SHADOW_CYCLES);

    br_state_t               state_r, state_nx;
    logic [SHADOW_CNT_W-1:0] cnt_r, cnt_nx;

    logic                    res_valid_r, res_valid_nx;
    logic                    taken_r, taken_nx;
    logic [ADDR_WIDTH-1:0]   target_r, target_nx;
    logic                    redirect_r, redirect_nx;
    logic                    illegal_r, illegal_nx;
    logic                    misalign_r, misalign_nx;

    logic                    cond_taken_s;
    logic                    cond_illegal_s;
    logic [ADDR_WIDTH-1:0]   sum_s;
    logic                    unaligned_s;
    logic                    accept_s;
    logic                    squash_s;

    branch_cond #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cond (
        .funct3  (br_funct3),
        .a       (rs1_data),
        .b       (rs2_data),
        .taken   (cond_taken_s),
        .illegal (cond_illegal_s)
    );

    // Target wraps modulo 2^ADDR_WIDTH by truncation.
    assign sum_s       = pc + imm;
    assign unaligned_s = |sum_s[1:0];
    assign accept_s    = br_valid & ~stall & ~flush_in & (state_r == IDLE);

    // Next-state, shadow counter and next result/pulse values.
    always_comb begin
        state_nx     = state_r;
        cnt_nx       = cnt_r;
        res_valid_nx = 1'b0;
        redirect_nx  = 1'b0;
        illegal_nx   = 1'b0;
        misalign_nx  = 1'b0;
        taken_nx     = taken_r;
        target_nx    = target_r;
        squash_s     = 1'b0;
        if (flush_in) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        res_valid_nx = 1'b1;
                        taken_nx     = cond_taken_s;
                        target_nx    = sum_s;
                        illegal_nx   = cond_illegal_s;
                        misalign_nx  = cond_taken_s & unaligned_s;
                        redirect_nx  = cond_taken_s & ~unaligned_s;
                        if (cond_taken_s & ~unaligned_s) begin
                            state_nx = SHADOW;
                            cnt_nx   = SHADOW_INIT;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        state_nx = IDLE;
                    end
                end
                SHADOW: begin
                    if (!stall) begin
                        squash_s = br_valid;
                        // Leaving on the edge where the count hits zero lets the
                        // very next cycle accept a branch.
                        if (cnt_r <= SHADOW_CNT_W'(1)) begin
                            state_nx = IDLE;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt_r - SHADOW_CNT_W'(1);
                        end
                    end else begin
                        squash_s = 1'b0;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // FSM state and shadow counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
        end
    end

    // Registered result fields and single-cycle pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r <= 1'b0;
            taken_r     <= 1'b0;
            target_r    <= '0;
            redirect_r  <= 1'b0;
            illegal_r   <= 1'b0;
            misalign_r  <= 1'b0;
        end else begin
            res_valid_r <= res_valid_nx;
            taken_r     <= taken_nx;
            target_r    <= target_nx;
            redirect_r  <= redirect_nx;
            illegal_r   <= illegal_nx;
            misalign_r  <= misalign_nx;
        end
    end

    assign res_valid = res_valid_r;
    assign taken     = taken_r;
    assign target    = target_r;
    assign redirect  = redirect_r;
    assign illegal   = illegal_r;
    assign misalign  = misalign_r;

`ifdef BRANCH_STATS_EN
    logic [31:0] taken_cnt_r;
    logic [31:0] not_taken_cnt_r;
    logic [31:0] squash_cnt_r;

    // Saturating statistics; illegal branches fall in neither taken bucket.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_r     <= 32'd0;
            not_taken_cnt_r <= 32'd0;
            squash_cnt_r    <= 32'd0;
        end else begin
            if (accept_s && !cond_illegal_s && cond_taken_s) begin
                taken_cnt_r <= sat_inc32(taken_cnt_r);
            end else begin
                taken_cnt_r <= taken_cnt_r;
            end
            if (accept_s && !cond_illegal_s && !cond_taken_s) begin
                not_taken_cnt_r <= sat_inc32(not_taken_cnt_r);
            end else begin
                not_taken_cnt_r <= not_taken_cnt_r;
            end
            if (squash_s) begin
                squash_cnt_r <= sat_inc32(squash_cnt_r);
            end else begin
                squash_cnt_r <= squash_cnt_r;
            end
        end
    end

    assign taken_cnt     = taken_cnt_r;
    assign not_taken_cnt = not_taken_cnt_r;
    assign squash_cnt    = squash_cnt_r;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_unit
// Directed, table-driven bench for branch_unit plus hand-written sequences
// for the shadow window, stall freeze, flush, async reset and (with
// BRANCH_STATS_EN) the statistics counters.
// ----------------------------------------------------------------------------
module tb_branch_unit;

    logic        clk;
    logic        rst_n;
    logic        br_valid;
    logic [2:0]  br_funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        stall;
    logic        flush_in;
    logic        res_valid;
    logic        taken;
    logic [31:0] target;
    logic        redirect;
    logic        illegal;
    logic        misalign;
`ifdef BRANCH_STATS_EN
    logic [31:0] taken_cnt;
    logic [31:0] not_taken_cnt;
    logic [31:0] squash_cnt;
`endif

    int n_cmp;
    int n_fail;

    branch_unit #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .SHADOW_CYCLES (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .br_valid      (br_valid),
        .br_funct3     (br_funct3),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .pc            (pc),
        .imm           (imm),
        .stall         (stall),
        .flush_in      (flush_in),
        .res_valid     (res_valid),
        .taken         (taken),
        .target        (target),
        .redirect      (redirect),
        .illegal       (illegal),
`ifdef BRANCH_STATS_EN
        .taken_cnt     (taken_cnt),
        .not_taken_cnt (not_taken_cnt),
        .squash_cnt    (squash_cnt),
`endif
        .misalign      (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        e_taken;
        logic [31:0] e_target;
        logic        e_redirect;
        logic        e_illegal;
        logic        e_misalign;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] i);
        br_valid  = 1'b1;
        br_funct3 = f3;
        rs1_data  = a;
        rs2_data  = b;
        pc        = p;
        imm       = i;
    endtask

    task automatic idle();
        br_valid = 1'b0;
    endtask

    task automatic check_pulses_low(input string nm);
        check({nm, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        check({nm, "_redirect"},  {31'd0, redirect},  32'd0);
        check({nm, "_illegal"},   {31'd0, illegal},   32'd0);
        check({nm, "_misalign"},  {31'd0, misalign},  32'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        br_valid  = 1'b0;
        br_funct3 = 3'b000;
        rs1_data  = 32'd0;
        rs2_data  = 32'd0;
        pc        = 32'd0;
        imm       = 32'd0;
        stall     = 1'b0;
        flush_in  = 1'b0;

        //            f3      a             b             pc            imm           tk    target        rd    il    mis
        vecs[0]  = '{3'b000, 32'd5,        32'd5,        32'h0000_0100, 32'h0000_0020, 1'b1, 32'h0000_0120, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{3'b100, 32'hFFFF_FFFF, 32'd1,       32'h0000_0200, 32'h0000_0010, 1'b1, 32'h0000_0210, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{3'b110, 32'hFFFF_FFFF, 32'd1,       32'h0000_0200, 32'h0000_0010, 1'b0, 32'h0000_0210, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'b111, 32'd3,        32'd3,        32'h0000_0300, 32'h0000_0004, 1'b1, 32'h0000_0304, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{3'b010, 32'd5,        32'd5,        32'h0000_0400, 32'h0000_0008, 1'b0, 32'h0000_0408, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{3'b011, 32'd1,        32'd2,        32'h0000_0400, 32'h0000_000C, 1'b0, 32'h0000_040C, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{3'b000, 32'd7,        32'd7,        32'h0000_0100, 32'h0000_0022, 1'b1, 32'h0000_0122, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{3'b001, 32'd1,        32'd2,        32'hFFFF_FFF0, 32'h0000_0020, 1'b1, 32'h0000_0010, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{3'b101, 32'h8000_0000, 32'd1,       32'h0000_0500, 32'hFFFF_FFFC, 1'b0, 32'h0000_04FC, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'b101, 32'd1,        32'h8000_0000, 32'h0000_0500, 32'hFFFF_FFFC, 1'b1, 32'h0000_04FC, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{3'b001, 32'd5,        32'd5,        32'h0000_0600, 32'h0000_0010, 1'b0, 32'h0000_0610, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{3'b110, 32'd1,        32'hFFFF_FFFF, 32'h0000_0700, 32'h0000_0008, 1'b1, 32'h0000_0708, 1'b1, 1'b0, 1'b0};

        // Reset values, checked while reset is held.
        #12;
        check_pulses_low("reset");
        check("reset_taken",  {31'd0, taken}, 32'd0);
        check("reset_target", target, 32'd0);
        rst_n = 1'b1;
        step();

        // Table: each vector accepted from IDLE; pulses must drop a cycle later,
        // and a redirect costs one more idle cycle before the next acceptance.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].imm);
            step();
            check($sformatf("v%0d_res_valid", i), {31'd0, res_valid}, 32'd1);
            check($sformatf("v%0d_taken", i),     {31'd0, taken},     {31'd0, vecs[i].e_taken});
            check($sformatf("v%0d_target", i),    target,             vecs[i].e_target);
            check($sformatf("v%0d_redirect", i),  {31'd0, redirect},  {31'd0, vecs[i].e_redirect});
            check($sformatf("v%0d_illegal", i),   {31'd0, illegal},   {31'd0, vecs[i].e_illegal});
            check($sformatf("v%0d_misalign", i),  {31'd0, misalign},  {31'd0, vecs[i].e_misalign});
            idle();
            step();
            check_pulses_low($sformatf("v%0d_drop", i));
            check($sformatf("v%0d_target_hold", i), target, vecs[i].e_target);
            if (vecs[i].e_redirect) begin
                step();
            end else begin
                check($sformatf("v%0d_drop_taken_hold", i), {31'd0, taken}, {31'd0, vecs[i].e_taken});
            end
        end

        // Back-to-back: not-taken BLTU then BGEU the very next cycle.
        drive(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h0000_0200, 32'h0000_0010);
        step();
        check("b2b_first_valid", {31'd0, res_valid}, 32'd1);
        check("b2b_first_taken", {31'd0, taken}, 32'd0);
        drive(3'b111, 32'd3, 32'd3, 32'h0000_0300, 32'h0000_0004);
        step();
        check("b2b_second_valid",  {31'd0, res_valid}, 32'd1);
        check("b2b_second_taken",  {31'd0, taken}, 32'd1);
        check("b2b_second_target", target, 32'h0000_0304);
        idle();
        step();
        step();

        // Stall inside the shadow freezes the counter.
        drive(3'b000, 32'd5, 32'd5, 32'h0000_0100, 32'h0000_0020);
        step();
        check("stall_acc_redirect", {31'd0, redirect}, 32'd1);
        stall = 1'b1;
        drive(3'b000, 32'd9, 32'd9, 32'h0000_0900, 32'h0000_0000);
        for (int k = 0; k < 3; k++) begin
            step();
            check_pulses_low($sformatf("stall%0d", k));
            check($sformatf("stall%0d_target_hold", k), target, 32'h0000_0120);
        end
        stall = 1'b0;
        step();
        check("unstall_sq1_valid", {31'd0, res_valid}, 32'd0);
        step();
        check("unstall_sq2_valid", {31'd0, res_valid}, 32'd0);
        step();
        check("unstall_acc_valid",    {31'd0, res_valid}, 32'd1);
        check("unstall_acc_target",   target, 32'h0000_0900);
        check("unstall_acc_redirect", {31'd0, redirect}, 32'd1);

        // Flush mid-shadow: drops same-cycle branch, next one accepted.
        flush_in = 1'b1;
        drive(3'b000, 32'd1, 32'd1, 32'h0000_0A00, 32'h0000_0000);
        step();
        check_pulses_low("flush_shadow");
        flush_in = 1'b0;
        drive(3'b001, 32'd5, 32'd5, 32'h0000_0A00, 32'h0000_0000);
        step();
        check("post_flush_valid",  {31'd0, res_valid}, 32'd1);
        check("post_flush_taken",  {31'd0, taken}, 32'd0);
        check("post_flush_target", target, 32'h0000_0A00);
        flush_in = 1'b1;
        drive(3'b000, 32'd1, 32'd1, 32'h0000_0B00, 32'h0000_0000);
        step();
        check_pulses_low("flush_idle");
        flush_in = 1'b0;
        idle();
        step();

        // Async reset mid-shadow clears outputs before the next clock edge.
        drive(3'b000, 32'd5, 32'd5, 32'h0000_0100, 32'h0000_0020);
        step();
        check("rst_pre_redirect", {31'd0, redirect}, 32'd1);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check_pulses_low("async_rst");
        check("async_rst_taken",  {31'd0, taken}, 32'd0);
        check("async_rst_target", target, 32'd0);
        #1;
        rst_n = 1'b1;
        drive(3'b001, 32'd1, 32'd1, 32'h0000_0040, 32'h0000_0004);
        step();
        check("post_rst_valid",  {31'd0, res_valid}, 32'd1);
        check("post_rst_target", target, 32'h0000_0044);
        idle();
        step();

        // Fresh reset, then 2 taken, 1 not-taken and 2 squashed branches.
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        drive(3'b000, 32'd5, 32'd5, 32'h0000_0100, 32'h0000_0020);
        step();
        check("st_acc1_valid", {31'd0, res_valid}, 32'd1);
        drive(3'b000, 32'd6, 32'd6, 32'h0000_0800, 32'h0000_0020);
        step();
        check("st_sq1_valid", {31'd0, res_valid}, 32'd0);
        step();
        check("st_sq2_valid", {31'd0, res_valid}, 32'd0);
        step();
        check("st_acc2_valid",  {31'd0, res_valid}, 32'd1);
        check("st_acc2_target", target, 32'h0000_0820);
        idle();
        step();
        step();
        drive(3'b001, 32'd5, 32'd5, 32'h0000_0C00, 32'h0000_0000);
        step();
        check("st_nt_valid", {31'd0, res_valid}, 32'd1);
        check("st_nt_taken", {31'd0, taken}, 32'd0);
        idle();
        step();
`ifdef BRANCH_STATS_EN
        check("taken_cnt",     taken_cnt,     32'd2);
        check("not_taken_cnt", not_taken_cnt, 32'd1);
        check("squash_cnt",    squash_cnt,    32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
